// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial-bit pattern detector.
// Samples i_x when i_x_valid is high and compares the last LEN bits against a
// runtime-loadable pattern with a per-bit care mask. It supports overlapping and
// non-overlapping matches and keeps a saturating match counter.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-high reset
//   i_x          serial data bit
//   i_x_valid    i_x is sampled on this edge when 1
//   i_pat_in     new pattern (MSB = first bit of the sequence)
//   i_mask_in    care mask for i_pat_in (1 = compare, 0 = don't-care)
//   i_pat_load   load pattern/mask and flush history (beats i_x_valid)
//   i_overlap_en 1 = overlapping matches, 0 = non-overlapping
//   i_cnt_clr    synchronous clear of o_match_cnt
//   o_z          registered one-cycle match pulse
//   o_match_cnt  saturating match count
//   o_armed      history holds LEN valid bits
module seq_detect_param #(
  parameter int unsigned       LEN         = 4,
  parameter logic [LEN-1:0]    DEFAULT_PAT = 4'b1011,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_x,
  input  logic             i_x_valid,
  input  logic [LEN-1:0]   i_pat_in,
  input  logic [LEN-1:0]   i_mask_in,
  input  logic             i_pat_load,
  input  logic             i_overlap_en,
  input  logic             i_cnt_clr,
  output logic             o_z,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_armed
);

  localparam int unsigned    FW      = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FillMax = FW'(LEN);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [LEN-1:0]   r_pat;
  logic [LEN-1:0]   r_mask;
  logic [LEN-1:0]   r_hist;
  logic [FW-1:0]    r_fill;
  logic             r_z;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  logic [LEN-1:0]   w_hist_n;
  logic [FW-1:0]    w_fill_inc;
  logic             w_match;
  logic [LEN-1:0]   w_pat_d;
  logic [LEN-1:0]   w_mask_d;
  logic [LEN-1:0]   w_hist_d;
  logic [FW-1:0]    w_fill_d;
  logic [CNT_W-1:0] w_cnt_d;

  assign w_hist_n   = {r_hist[LEN-2:0], i_x};
  assign w_fill_inc = (r_fill == FillMax) ? FillMax : r_fill + FW'(1);
  // A load on the same edge suppresses any match from the incoming bit.
  assign w_match    = i_x_valid && !i_pat_load && (w_fill_inc == FillMax) &&
                      (((w_hist_n ^ r_pat) & r_mask) == '0);

  always_comb begin
    w_pat_d  = r_pat;
    w_mask_d = r_mask;
    w_hist_d = r_hist;
    w_fill_d = r_fill;
    if (i_pat_load) begin
      w_pat_d  = i_pat_in;
      w_mask_d = i_mask_in;
      w_hist_d = '0;
      w_fill_d = '0;
    end else if (i_x_valid) begin
      w_hist_d = w_hist_n;
      // Non-overlapping mode restarts the fill so LEN fresh bits are needed.
      w_fill_d = (w_match && !i_overlap_en) ? '0 : w_fill_inc;
    end
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_cnt_clr) begin
      // A match coinciding with the clear is still counted.
      w_cnt_d = w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != CntMax)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pat   <= DEFAULT_PAT;
      r_mask  <= '1;
      r_hist  <= '0;
      r_fill  <= '0;
      r_z     <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_pat   <= w_pat_d;
      r_mask  <= w_mask_d;
      r_hist  <= w_hist_d;
      r_fill  <= w_fill_d;
      r_z     <= w_match;
      r_cnt   <= w_cnt_d;
      r_armed <= (w_fill_d == FillMax);
    end
  end

  assign o_z         = r_z;
  assign o_match_cnt = r_cnt;
  assign o_armed     = r_armed;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param (LEN=3, DEFAULT_PAT=3'b011, CNT_W=2).
module tb_seq_detect_param;

  logic       i_clk;
  logic       i_reset;
  logic       i_x;
  logic       i_x_valid;
  logic [2:0] i_pat_in;
  logic [2:0] i_mask_in;
  logic       i_pat_load;
  logic       i_overlap_en;
  logic       i_cnt_clr;
  logic       o_z;
  logic [1:0] o_match_cnt;
  logic       o_armed;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_param #(
    .LEN        (3),
    .DEFAULT_PAT(3'b011),
    .CNT_W      (2)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_x         (i_x),
    .i_x_valid   (i_x_valid),
    .i_pat_in    (i_pat_in),
    .i_mask_in   (i_mask_in),
    .i_pat_load  (i_pat_load),
    .i_overlap_en(i_overlap_en),
    .i_cnt_clr   (i_cnt_clr),
    .o_z         (o_z),
    .o_match_cnt (o_match_cnt),
    .o_armed     (o_armed)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic x, input logic v, input logic load, input logic clr);
    i_x        = x;
    i_x_valid  = v;
    i_pat_load = load;
    i_cnt_clr  = clr;
    @(posedge i_clk);
    #1;
    i_x_valid  = 1'b0;
    i_pat_load = 1'b0;
    i_cnt_clr  = 1'b0;
  endtask

  task automatic load_pat(input logic [2:0] pat, input logic [2:0] mask);
    i_pat_in  = pat;
    i_mask_in = mask;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_x = 1'b0; i_x_valid = 1'b0; i_pat_in = '0; i_mask_in = '0;
    i_pat_load = 1'b0; i_overlap_en = 1'b1; i_cnt_clr = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_z, o_match_cnt, o_armed} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset: z/cnt/armed=%b required 0000", {o_z, o_match_cnt, o_armed});
    end
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_default();
    logic [0:10] stream = 11'b01101101111;
    logic [0:10] z_exp  = 11'b00100100100;
    logic [0:10] a_exp  = 11'b00111111111;
    i_overlap_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cycle(stream[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== z_exp[i] || o_armed !== a_exp[i]) begin
        n_err++;
        $display("FAIL default bit%0d: z=%b armed=%b required z=%b armed=%b",
                 i + 1, o_z, o_armed, z_exp[i], a_exp[i]);
      end
    end
    n_cmp++;
    if (o_match_cnt !== 2'd3) begin
      n_err++;
      $display("FAIL default cnt: got %0d required 3", o_match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [0:4] stream  = 5'b10101;
    logic [0:4] z_ov    = 5'b00101;
    logic [0:5] stream2 = 6'b101010;
    logic [0:5] z_no    = 6'b001000;
    logic [0:5] a_no    = 6'b000001;
    load_pat(3'b101, 3'b111);
    i_overlap_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(stream[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== z_ov[i]) begin
        n_err++;
        $display("FAIL overlap bit%0d: z=%b required %b", i + 1, o_z, z_ov[i]);
      end
    end
    n_cmp++;
    if (o_match_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL overlap cnt: got %0d required 2", o_match_cnt);
    end
    load_pat(3'b101, 3'b111);
    i_overlap_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(stream2[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== z_no[i] || o_armed !== a_no[i]) begin
        n_err++;
        $display("FAIL nonoverlap bit%0d: z=%b armed=%b required z=%b armed=%b",
                 i + 1, o_z, o_armed, z_no[i], a_no[i]);
      end
    end
    n_cmp++;
    if (o_match_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL nonoverlap cnt: got %0d required 1", o_match_cnt);
    end
    i_overlap_en = 1'b1;
  endtask

  task automatic test_mask_gaps();
    load_pat(3'b101, 3'b101);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== 1'b0 || o_armed !== 1'b0) begin
        n_err++;
        $display("FAIL gap%0d: z=%b armed=%b required z=0 armed=0", g, o_z, o_armed);
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (o_z !== 1'b1 || o_armed !== 1'b1) begin
      n_err++;
      $display("FAIL mask match: z=%b armed=%b required z=1 armed=1", o_z, o_armed);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_z !== 1'b0) begin
      n_err++;
      $display("FAIL mask pulse width: z=%b required 0", o_z);
    end
  endtask

  task automatic test_reload();
    logic [0:2] stream = 3'b110;
    logic [0:2] z_exp  = 3'b001;
    load_pat(3'b011, 3'b111);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    // This bit would complete 011 but the load wins and discards it.
    i_pat_in  = 3'b110;
    i_mask_in = 3'b111;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (o_z !== 1'b0 || o_armed !== 1'b0) begin
      n_err++;
      $display("FAIL reload edge: z=%b armed=%b required z=0 armed=0", o_z, o_armed);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(stream[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== z_exp[i]) begin
        n_err++;
        $display("FAIL reload bit%0d: z=%b required %b", i + 1, o_z, z_exp[i]);
      end
    end
  endtask

  task automatic test_counter();
    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load_pat(3'b000, 3'b000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(i[0], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== 1'b1 || o_match_cnt !== cnt_exp[i]) begin
        n_err++;
        $display("FAIL counter match%0d: z=%b cnt=%0d required z=1 cnt=%0d",
                 i + 1, o_z, o_match_cnt, cnt_exp[i]);
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (o_match_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL clr with match: cnt=%0d required 1", o_match_cnt);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_match_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clr alone: cnt=%0d required 0", o_match_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [0:4] stream = 5'b11011;
    logic [0:4] z_exp  = 5'b00001;
    load_pat(3'b110, 3'b111);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (o_z !== 1'b1 || o_match_cnt !== 2'd1 || o_armed !== 1'b1) begin
      n_err++;
      $display("FAIL pre-reset match: z=%b cnt=%0d armed=%b required z=1 cnt=1 armed=1",
               o_z, o_match_cnt, o_armed);
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_cmp++;
    if ({o_z, o_match_cnt, o_armed} !== 4'b0000) begin
      n_err++;
      $display("FAIL async reset: z/cnt/armed=%b required 0000", {o_z, o_match_cnt, o_armed});
    end
    #1;
    i_reset = 1'b0;
    // 110 must no longer match; default 011 must.
    for (int i = 0; i < 5; i++) begin
      cycle(stream[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_z !== z_exp[i]) begin
        n_err++;
        $display("FAIL post-reset bit%0d: z=%b required %b", i + 1, o_z, z_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_mask_gaps();
    test_reload();
    test_counter();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial-bit pattern detector. It is the successor to the fixed single-pattern sequence detector. The block samples a 1-bit input stream under a valid qualifier and compares the last LEN bits against a runtime-loadable pattern with per-bit don't-care mask. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits between a serial front end and control logic that consumes the z pulse and the count.

Parameters:
LEN, 4, pattern length in bits (2..32)
DEFAULT_PAT, 4'b1011, pattern loaded at reset (LEN bits; MSB = first bit received)
CNT_W, 8, width of match counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
x  input  1  serial data bit
x_valid  input  1  x sampled on this edge when 1
pat_in  input  LEN  new pattern (MSB = first bit of sequence)
mask_in  input  LEN  care mask for pat_in; 1 = compare, 0 = don't-care
pat_load  input  1  load pat_in/mask_in, flush history
overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
z  output  1  registered match pulse
match_cnt  output  CNT_W  saturating count of matches
armed  output  1  history holds LEN valid bits

Behaviour:
- Reset (async, active-high): pattern=DEFAULT_PAT, mask=all ones, hist=0, fill=0, z=0, match_cnt=0, armed=0.
- State: hist[LEN-1:0] shift register; fill counter 0..LEN; pattern/mask registers.
- Priority per edge: reset > pat_load > x_valid.
- pat_load=1: pattern<=pat_in, mask<=mask_in, hist<=0, fill<=0, z<=0. x is ignored that edge even if x_valid=1. match_cnt is unaffected unless cnt_clr.
- x_valid=1 (no pat_load): hist_n={hist[LEN-2:0],x}; fill_n=min(fill+1,LEN).
  - match = (fill_n==LEN) && (((hist_n ^ pattern) & mask) == 0).
  - hist<=hist_n; z<=match.
- On match with overlap_en=0: fill<=0. hist still loads hist_n, but no match is possible until LEN new bits arrive.
- On match with overlap_en=1: fill stays LEN, so the next bit can match again.
- x_valid=0: hist and fill hold; z<=0.
- Latency: z is high for exactly one cycle, on the edge that samples the final pattern bit. It is visible in the following cycle. Back-to-back matches give consecutive z=1 cycles.
- armed = (fill==LEN), registered with fill.
- mask all zeros: every valid bit matches once fill reaches LEN.
- match_cnt increments on each edge where match=1 and saturates at 2^CNT_W-1.
- cnt_clr=1 with no match: match_cnt<=0.
- cnt_clr=1 with match on the same edge: match_cnt<=1, so the match is not lost.
- overlap_en may change at any time. It is sampled on the match edge only.
- Reset asserted mid-stream: all state returns to reset values immediately. The pattern reverts to DEFAULT_PAT.
- Reset deassertion: the first sampled bit is the edge after reset falls.

Test Plan:
- Default: LEN=3, DEFAULT_PAT=3'b011, overlap_en=1. Stream 0,1,1,0,1,1,0,1,1,1,1 with x_valid=1 -> z pulses on bits 3, 6 and 9 only; match_cnt=3; armed=1 from bit 3.
- Overlap vs non-overlap: load pattern 101, mask 111. Stream 1,0,1,0,1 -> overlap_en=1 gives z on bits 3 and 5 (cnt=2). overlap_en=0 gives z on bit 3 only (cnt=1); armed drops after the match and returns on bit 6.
- Mask/gaps: pattern 1x1 (pat 101, mask 101). Stream 1,1,1 with x_valid low for 2 cycles between bits 2 and 3 -> single z on bit 3; z=0 during gap cycles; hist unchanged across the gap.
- Reload mid-stream: after bits 0,1 of the 011 pattern, assert pat_load with pat 110 and x_valid=1 -> that x is ignored, armed=0. Stream 1,1,0 -> z on the third bit after the load; old pattern never fires.
- Counter: CNT_W=2, 5 matches -> match_cnt sequence 1,2,3,3,3. cnt_clr together with the 6th match -> match_cnt=1. cnt_clr alone -> 0.
- Async reset: assert reset between edges mid-match -> z, match_cnt, armed go 0 without waiting for a clock edge; the pattern returns to default; the next matching stream after release detects normally.
